// File: rtl/sdram_rw_arbiter.sv
// Burst scheduler sharing one SDRAM controller port between the camera write
// FIFO and the LCD read FIFO; generates linear frame-buffer burst addresses.
module sdram_rw_arbiter #(
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 384000,
    parameter int ADDR_W      = 24,
    parameter int FIFO_AW     = 10,
    parameter int RD_LOW      = 256,
    parameter int WR_HIGH     = 768
) (
    input  logic               clk_ref,
    input  logic               rst_n,
    input  logic               sdram_init_done,
    input  logic               frame_valid,
    input  logic [FIFO_AW-1:0] wr_usedw,
    input  logic [FIFO_AW-1:0] rd_usedw,
    output logic               sdram_wr_req,
    output logic               sdram_rd_req,
    output logic [ADDR_W-1:0]  sdram_addr,
    input  logic               sdram_ack,
    input  logic               sdram_done,
    output logic               busy,
    output logic [7:0]         wr_frame_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_WAIT = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;

    // Levels are compared one bit wider so the full FIFO depth is representable.
    localparam logic [FIFO_AW:0] RD_LOW_L   = (FIFO_AW+1)'(RD_LOW);
    localparam logic [FIFO_AW:0] WR_HIGH_L  = (FIFO_AW+1)'(WR_HIGH);
    localparam logic [FIFO_AW:0] BURST_L    = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] RD_ROOM_L  = (FIFO_AW+1)'((1 << FIFO_AW) - BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - BURST_LEN);

    logic [2:0]        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              last_grant_wr;
    logic              wr_restart_pend;
    logic [1:0]        fv_sync;
    logic              fv_last;
    logic              fv_rise;

    logic              rd_urgent;
    logic              wr_urgent;
    logic              grant_wr;
    logic              grant_rd;
    logic              evaluate;
    logic              wr_finish;
    logic              rd_finish;
    logic              wr_wrap;
    logic              rd_wrap;
    logic [ADDR_W-1:0] wr_next;
    logic [ADDR_W-1:0] rd_next;

    assign fv_rise   = fv_sync[1] & ~fv_last;
    assign evaluate  = (state == IDLE) & sdram_init_done;
    assign rd_urgent = {1'b0, rd_usedw} < RD_LOW_L;
    assign wr_urgent = {1'b0, wr_usedw} >= WR_HIGH_L;

    // An ack and done in the same cycle finish the burst straight from REQ.
    assign wr_finish = sdram_done & (((state == WR_REQ) & sdram_ack) | (state == WR_WAIT));
    assign rd_finish = sdram_done & (((state == RD_REQ) & sdram_ack) | (state == RD_WAIT));

    assign wr_wrap = (wr_addr == LAST_ADDR);
    assign rd_wrap = (rd_addr == LAST_ADDR);
    assign wr_next = wr_wrap ? '0 : wr_addr + STEP;
    assign rd_next = rd_wrap ? '0 : rd_addr + STEP;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (evaluate) begin
            if (rd_urgent && wr_urgent) begin
                grant_wr = ~last_grant_wr;
                grant_rd = last_grant_wr;
            end else if (wr_urgent) begin
                grant_wr = 1'b1;
            end else if (rd_urgent) begin
                grant_rd = 1'b1;
            end else if ({1'b0, wr_usedw} >= BURST_L) begin
                grant_wr = 1'b1;
            end else if ({1'b0, rd_usedw} <= RD_ROOM_L) begin
                grant_rd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            fv_sync <= '0;
            fv_last <= 1'b0;
        end else begin
            fv_sync <= {fv_sync[0], frame_valid};
            fv_last <= fv_sync[1];
        end
    end

    // A new edge arriving in the clearing cycle keeps the restart pending.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n)
            wr_restart_pend <= 1'b0;
        else
            wr_restart_pend <= fv_rise | (wr_restart_pend & ~evaluate);
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_addr    <= '0;
            busy          <= 1'b0;
            wr_frame_cnt  <= '0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            last_grant_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (evaluate && wr_restart_pend)
                        wr_addr <= '0;
                    if (grant_wr) begin
                        state         <= WR_REQ;
                        sdram_wr_req  <= 1'b1;
                        busy          <= 1'b1;
                        last_grant_wr <= 1'b1;
                        sdram_addr    <= wr_restart_pend ? '0 : wr_addr;
                    end else if (grant_rd) begin
                        state         <= RD_REQ;
                        sdram_rd_req  <= 1'b1;
                        busy          <= 1'b1;
                        last_grant_wr <= 1'b0;
                        sdram_addr    <= rd_addr;
                    end
                end
                WR_REQ: begin
                    if (sdram_ack) begin
                        sdram_wr_req <= 1'b0;
                        state        <= WR_WAIT;
                    end
                end
                RD_REQ: begin
                    if (sdram_ack) begin
                        sdram_rd_req <= 1'b0;
                        state        <= RD_WAIT;
                    end
                end
                WR_WAIT, RD_WAIT: ;
                default: begin
                    state        <= IDLE;
                    sdram_wr_req <= 1'b0;
                    sdram_rd_req <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase

            if (wr_finish) begin
                state      <= IDLE;
                busy       <= 1'b0;
                wr_addr    <= wr_next;
                sdram_addr <= wr_next;
                if (wr_wrap)
                    wr_frame_cnt <= wr_frame_cnt + 8'd1;
            end
            if (rd_finish) begin
                state      <= IDLE;
                busy       <= 1'b0;
                rd_addr    <= rd_next;
                sdram_addr <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench for sdram_rw_arbiter: a transaction-level model is checked
// every cycle, plus hand-computed burst addresses and grant orders.
module tb_sdram_rw_arbiter;

    localparam int BL = 256, FW = 384000, AW = 24, FAW = 10, RDL = 256, WRH = 768;

    logic clk_ref = 1'b0, rst_n = 1'b1, init_done = 1'b0, frame_valid = 1'b0;
    logic ack = 1'b0, done = 1'b0;
    logic [FAW-1:0] wr_usedw = '0, rd_usedw = '0;
    logic wr_req, rd_req, busy;
    logic [AW-1:0] addr;
    logic [7:0] frame_cnt;

    int checks = 0, errors = 0;
    bit cmp_on = 1'b0;

    // Model: one burst in flight (active/dir/acked), addresses as plain integers.
    bit m_active, m_dir, m_acked, m_last_wr, m_restart, m_fv_prev;
    int m_wr_addr, m_rd_addr, m_frames, m_addr;

    sdram_rw_arbiter dut (
        .clk_ref(clk_ref), .rst_n(rst_n), .sdram_init_done(init_done),
        .frame_valid(frame_valid), .wr_usedw(wr_usedw), .rd_usedw(rd_usedw),
        .sdram_wr_req(wr_req), .sdram_rd_req(rd_req), .sdram_addr(addr),
        .sdram_ack(ack), .sdram_done(done), .busy(busy), .wr_frame_cnt(frame_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // 1 = write, 2 = read, 0 = none
    function automatic int grant(input int w, input int r, input bit last_wr);
        bit ru = (r < RDL);
        bit wu = (w >= WRH);
        if (ru && wu) return last_wr ? 2 : 1;
        if (wu) return 1;
        if (ru) return 2;
        if (w >= BL) return 1;
        if (r <= (1 << FAW) - BL) return 2;
        return 0;
    endfunction

    task automatic model_step();
        int g;
        if (!rst_n) begin
            m_active = 0; m_dir = 0; m_acked = 0; m_last_wr = 0; m_restart = 0; m_fv_prev = 0;
            m_wr_addr = 0; m_rd_addr = 0; m_frames = 0; m_addr = 0;
            return;
        end
        if (!m_active) begin
            if (init_done) begin
                if (m_restart) begin
                    m_wr_addr = 0;
                    m_restart = 0;
                end
                g = grant(int'(wr_usedw), int'(rd_usedw), m_last_wr);
                if (g != 0) begin
                    m_active = 1; m_acked = 0; m_dir = (g == 1); m_last_wr = m_dir;
                    m_addr = m_dir ? m_wr_addr : m_rd_addr;
                end
            end
        end else begin
            if (ack) m_acked = 1;
            if (m_acked && done) begin
                m_active = 0;
                if (m_dir) begin
                    m_wr_addr = (m_wr_addr + BL == FW) ? 0 : m_wr_addr + BL;
                    if (m_wr_addr == 0) m_frames = (m_frames + 1) % 256;
                    m_addr = m_wr_addr;
                end else begin
                    m_rd_addr = (m_rd_addr + BL == FW) ? 0 : m_rd_addr + BL;
                    m_addr = m_rd_addr;
                end
            end
        end
        if (frame_valid && !m_fv_prev) m_restart = 1;
        m_fv_prev = frame_valid;
    endtask

    initial forever begin
        @(posedge clk_ref);
        model_step();
    end

    initial forever begin
        @(negedge clk_ref);
        if (cmp_on) begin
            if (!rst_n) begin
                check("rst_wr_req", wr_req, 0);
                check("rst_rd_req", rd_req, 0);
                check("rst_busy", busy, 0);
                check("rst_addr", addr, 0);
                check("rst_frame_cnt", frame_cnt, 0);
            end else begin
                check("wr_req", wr_req, m_active && m_dir && !m_acked);
                check("rd_req", rd_req, m_active && !m_dir && !m_acked);
                check("busy", busy, m_active);
                check("addr", addr, m_addr);
                check("frame_cnt", frame_cnt, m_frames);
            end
            check("req_onehot", wr_req & rd_req, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ack = 1'b0; done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!(wr_req || rd_req) && n < 40) begin
            tick();
            n++;
        end
        if (!(wr_req || rd_req)) check({name, "_timeout"}, wr_req | rd_req, 1);
    endtask

    // Serve one burst; the FIFO levels switch to nwr/nrd together with the ack.
    task automatic burst(input string name, input bit exp_wr, input int exp_addr,
                         input int dly, input int nwr, input int nrd);
        wait_req(name);
        check({name, "_dir"}, wr_req, exp_wr);
        check({name, "_addr"}, addr, exp_addr);
        wr_usedw = FAW'(nwr);
        rd_usedw = FAW'(nrd);
        if (dly == 0) begin
            ack = 1'b1; done = 1'b1;
            tick();
            ack = 1'b0; done = 1'b0;
        end else begin
            ack = 1'b1;
            tick();
            ack = 1'b0;
            repeat (dly - 1) tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 cmp_on = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_addr", addr, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("idle_no_init", busy, 0);

        // write only: request one cycle after the grant condition appears
        wr_usedw = 10'd256; rd_usedw = 10'd1000; init_done = 1'b1;
        tick();
        check("lat_wr_req", wr_req, 1);
        burst("w0", 1, 0, 3, 256, 1000);
        burst("w1", 1, 256, 1, 0, 1000);
        repeat (4) tick();
        check("w_idle", busy, 0);

        // read urgency wins over a non-urgent write
        wr_usedw = 10'd300; rd_usedw = 10'd100;
        do_reset();
        burst("ru_r", 0, 0, 2, 300, 1000);
        burst("ru_w", 1, 0, 2, 0, 1000);

        // both urgent: alternate starting with write
        wr_usedw = 10'd800; rd_usedw = 10'd0;
        do_reset();
        burst("bu0", 1, 0, 1, 800, 0);
        burst("bu1", 0, 0, 0, 800, 0);
        burst("bu2", 1, 256, 2, 800, 0);
        burst("bu3", 0, 256, 1, 0, 1000);

        // wrap at the frame end
        wr_usedw = 10'd256; rd_usedw = 10'd1000;
        do_reset();
        for (int i = 0; i < 1500; i++)
            burst("wrap", 1, i * BL, 0, (i == 1499) ? 0 : 256, 1000);
        check("wrap_addr", addr, 0);
        check("wrap_frame_cnt", frame_cnt, 1);
        repeat (3) tick();

        // camera restart during a write burst
        wr_usedw = 10'd0; rd_usedw = 10'd100;
        do_reset();
        burst("rs_r0", 0, 0, 2, 256, 1000);
        burst("rs_w0", 1, 0, 1, 256, 1000);
        burst("rs_w1", 1, 256, 1, 256, 1000);
        wait_req("rs_w2");
        check("rs_w2_addr", addr, 512);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        frame_valid = 1'b1;
        repeat (8) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("rs_done_addr", addr, 768);
        burst("rs_w3", 1, 0, 2, 0, 100);
        burst("rs_r1", 0, 256, 2, 0, 1000);
        frame_valid = 1'b0;
        repeat (4) tick();

        // asynchronous reset while waiting for a read burst
        rd_usedw = 10'd100;
        wait_req("mr");
        check("mr_dir", rd_req, 1);
        check("mr_addr", addr, 512);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("mr_rst_busy", busy, 0);
        check("mr_rst_addr", addr, 0);
        check("mr_rst_rd_req", rd_req, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        burst("mr_post", 0, 0, 2, 0, 1000);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
